// File: rtl/pci_master32_req_ctrl_pkg.sv
// Shared constants for the PCI master request sequencer: master status codes,
// completion codes and the sequencer state encoding.
package pci_master32_req_ctrl_pkg;

   localparam logic [3:0] ST_WAIT         = 4'h0;
   localparam logic [3:0] ST_TRANSFERED   = 4'h1;
   localparam logic [3:0] ST_RETRY        = 4'h2;
   localparam logic [3:0] ST_DISC_WO_DATA = 4'h3;
   localparam logic [3:0] ST_DISC_W_DATA  = 4'h4;
   localparam logic [3:0] ST_TABORT       = 4'h5;
   localparam logic [3:0] ST_MABORT       = 4'h6;

   localparam logic [1:0] DC_OK        = 2'd0;
   localparam logic [1:0] DC_TABORT    = 2'd1;
   localparam logic [1:0] DC_MABORT    = 2'd2;
   localparam logic [1:0] DC_RETRY_LIM = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ISSUE   = 3'd2,
      S_BACKOFF = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // A data phase completed on the bus (with or without a following disconnect).
   function automatic logic is_data_st(input logic [3:0] s);
      return (s == ST_TRANSFERED) || (s == ST_DISC_W_DATA);
   endfunction

endpackage

// File: rtl/pci_master32_req_ctrl_if.sv
// Backend and master-facing signal bundle of the request sequencer.
// Handshakes (cmd, wdata, rdata): a beat moves on a rising edge where valid and ready are both 1.
interface pci_master32_req_ctrl_if #(parameter int DEPTH = 16);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [31:0]   cmd_addr_i;
   logic [3:0]    cmd_bc_i;
   logic [3:0]    cmd_be_i;
   logic [LW-1:0] cmd_len_i;
   logic [31:0]   wdata_i;
   logic          wvalid_i;
   logic          wready_o;
   logic [31:0]   rdata_o;
   logic          rvalid_o;
   logic          rready_i;
   logic          done_o;
   logic [1:0]    done_code_o;
   logic [31:0]   address_o;
   logic [3:0]    bc_o;
   logic [31:0]   data_o;
   logic [3:0]    be_o;
   logic          req_o;
   logic          rdy_o;
   logic          last_o;
   logic [3:0]    status_i;
   logic [31:0]   mdata_i;

   modport master (
      input  cmd_valid_i, cmd_addr_i, cmd_bc_i, cmd_be_i, cmd_len_i,
             wdata_i, wvalid_i, rready_i, status_i, mdata_i,
      output cmd_ready_o, wready_o, rdata_o, rvalid_o, done_o, done_code_o,
             address_o, bc_o, data_o, be_o, req_o, rdy_o, last_o
   );

   modport slave (
      output cmd_valid_i, cmd_addr_i, cmd_bc_i, cmd_be_i, cmd_len_i,
             wdata_i, wvalid_i, rready_i, status_i, mdata_i,
      input  cmd_ready_o, wready_o, rdata_o, rvalid_o, done_o, done_code_o,
             address_o, bc_o, data_o, be_o, req_o, rdy_o, last_o
   );

endinterface

// File: rtl/pci_master32_req_buf.sv
// Store-and-forward write beat buffer: synchronous write, asynchronous read by beat pointer.
module pci_master32_req_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pci_master32_req_ctrl.sv
// PCI master request sequencer: one descriptor at a time, write data replayed from the buffer
// after retry/disconnect. Define PCI_MASTER_RETRY_LIMIT_EN to bound retries (code 3). BACKOFF_CYC >= 1.
module pci_master32_req_ctrl
   import pci_master32_req_ctrl_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int BACKOFF_CYC = 2,
   parameter int RETRY_MAX   = 255
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   pci_master32_req_ctrl_if.master bus,
   output state_t                 dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(BACKOFF_CYC + 1);

   state_t        state, next_state;
   logic [1:0]    code_nxt;
   logic [31:0]   base_q;
   logic [3:0]    bc_q, be_q;
   logic [LW-1:0] len_q, fill, fill_nxt;
   logic [AW-1:0] ptr;
   logic [BW-1:0] bo_cnt;
   logic          cmd_ready_q, wready_q, req_q, done_q;
   logic [1:0]    code_q;
   logic [31:0]   buf_rdata;
   logic          accept, wr_en, in_issue, rdy_int, last_int, data_st, retry_st, xfer, retry_hit;
   logic [1:0]    unused_bits;

   assign accept   = (state == S_IDLE) && bus.cmd_valid_i && cmd_ready_q;
   assign wr_en    = (state == S_LOAD) && bus.wvalid_i && wready_q;
   assign fill_nxt = fill + LW'(wr_en);
   assign in_issue = (state == S_ISSUE);
   assign rdy_int  = in_issue && (bc_q[0] || bus.rready_i);
   assign last_int = ({1'b0, ptr} == (len_q - LW'(1)));
   assign data_st  = is_data_st(bus.status_i);
   assign retry_st = (bus.status_i == ST_RETRY) || (bus.status_i == ST_DISC_WO_DATA);
   assign xfer     = data_st && rdy_int;
   assign unused_bits = bus.cmd_addr_i[1:0];

`ifdef PCI_MASTER_RETRY_LIMIT_EN
   localparam int RCW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   logic [RCW-1:0] retry_cnt;

   assign retry_hit = (retry_cnt == RCW'(RETRY_MAX));

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in)                                retry_cnt <= '0;
      else if (accept)                              retry_cnt <= '0;
      else if (in_issue && retry_st && !retry_hit)  retry_cnt <= retry_cnt + RCW'(1);
   end
`else
   logic unused_retry_max;
   assign retry_hit        = 1'b0;
   assign unused_retry_max = (RETRY_MAX > 0);
`endif

   pci_master32_req_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk   (clk_in),
      .we    (wr_en),
      .waddr (fill[AW-1:0]),
      .wdata (bus.wdata_i),
      .raddr (ptr),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) state <= S_IDLE;
      else           state <= next_state;
   end

   always_comb begin
      next_state = state;
      code_nxt   = DC_OK;
      case (state)
         S_IDLE:  if (accept) next_state = bus.cmd_bc_i[0] ? S_LOAD : S_ISSUE;
         S_LOAD:  if (fill == len_q) next_state = S_ISSUE;
         S_ISSUE: begin
            if (xfer && last_int) begin
               next_state = S_DONE;
            end else if (bus.status_i == ST_DISC_W_DATA) begin
               next_state = S_BACKOFF;
            end else if (retry_st) begin
               next_state = retry_hit ? S_DONE : S_BACKOFF;
               code_nxt   = retry_hit ? DC_RETRY_LIM : DC_OK;
            end else if (bus.status_i == ST_TABORT) begin
               next_state = S_DONE;
               code_nxt   = DC_TABORT;
            end else if (bus.status_i == ST_MABORT) begin
               next_state = S_DONE;
               code_nxt   = DC_MABORT;
            end
         end
         S_BACKOFF: if (bo_cnt == BW'(BACKOFF_CYC - 1)) next_state = S_ISSUE;
         S_DONE:    next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // Master-facing data path is only driven while a request is on the bus.
   always_comb begin
      bus.address_o = '0;
      bus.data_o    = '0;
      bus.last_o    = 1'b0;
      bus.rdy_o     = 1'b0;
      bus.rvalid_o  = 1'b0;
      bus.rdata_o   = '0;
      if (in_issue) begin
         bus.address_o = base_q + (32'(ptr) << 2);
         bus.data_o    = buf_rdata;
         bus.last_o    = last_int;
         bus.rdy_o     = rdy_int;
         bus.rvalid_o  = !bc_q[0] && data_st;
         bus.rdata_o   = bus.mdata_i;
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         base_q      <= '0;
         bc_q        <= '0;
         be_q        <= '0;
         len_q       <= '0;
         fill        <= '0;
         ptr         <= '0;
         bo_cnt      <= '0;
         cmd_ready_q <= 1'b0;
         wready_q    <= 1'b0;
         req_q       <= 1'b0;
         done_q      <= 1'b0;
         code_q      <= DC_OK;
      end else begin
         cmd_ready_q <= (next_state == S_IDLE);
         req_q       <= (next_state == S_ISSUE);
         done_q      <= (next_state == S_DONE);
         code_q      <= (next_state == S_DONE) ? code_nxt : DC_OK;
         bo_cnt      <= (state == S_BACKOFF) ? bo_cnt + BW'(1) : '0;
         if (state == S_IDLE) wready_q <= accept && bus.cmd_bc_i[0];
         else                 wready_q <= (state == S_LOAD) && (fill_nxt < len_q);
         if (accept) begin
            base_q <= {bus.cmd_addr_i[31:2], 2'b00};
            bc_q   <= bus.cmd_bc_i;
            be_q   <= bus.cmd_be_i;
            len_q  <= (bus.cmd_len_i == '0) ? LW'(1) : bus.cmd_len_i;
            fill   <= '0;
            ptr    <= '0;
         end else begin
            if (state == S_LOAD) fill <= fill_nxt;
            if (xfer)            ptr  <= ptr + AW'(1);
         end
      end
   end

   assign bus.cmd_ready_o = cmd_ready_q;
   assign bus.wready_o    = wready_q;
   assign bus.req_o       = req_q;
   assign bus.done_o      = done_q;
   assign bus.done_code_o = code_q;
   assign bus.bc_o        = bc_q;
   assign bus.be_o        = be_q;
   assign dbg_state       = state;

endmodule
